// File: rtl/add32_seq_ctrl.sv
// 32-bit add/subtract unit that reuses one 8-bit ripple-carry adder across four
// byte slices, LSB first, under a small IDLE/RUN/DONE controller.

module add8_rca (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    logic [8:0] c;

    // Bit-serial carry chain
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[8];
endmodule

module add32_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Sum,
    output logic        Cout,
    output logic        Ovf,
    output logic        busy,
    output logic        done
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned SLICE_W = 8;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic                carry, carry_nxt;
    logic                sub_q, sub_nxt;
    logic [WORD_W-1:0]   opa, opa_nxt;
    logic [WORD_W-1:0]   opb, opb_nxt;
    logic [WORD_W-1:0]   sum_nxt;
    logic                cout_nxt, ovf_nxt, busy_nxt, done_nxt;

    logic [SLICE_W-1:0]  add_a, add_b, add_s;
    logic                add_cin, add_co;

    // LSB slice takes its carry-in from the latched operation; later slices chain.
    assign add_a   = opa[{idx, 3'b000} +: SLICE_W];
    assign add_b   = opb[{idx, 3'b000} +: SLICE_W];
    assign add_cin = (idx == IDX_W'(0)) ? sub_q : carry;

    add8_rca u_add8 (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            sub_q <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            carry <= carry_nxt;
            sub_q <= sub_nxt;
            opa   <= opa_nxt;
            opb   <= opb_nxt;
            Sum   <= sum_nxt;
            Cout  <= cout_nxt;
            Ovf   <= ovf_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        carry_nxt = carry;
        sub_nxt   = sub_q;
        opa_nxt   = opa;
        opb_nxt   = opb;
        sum_nxt   = Sum;
        cout_nxt  = Cout;
        ovf_nxt   = Ovf;

        case (state)
            IDLE: begin
                if (start) begin
                    opa_nxt   = A;
                    opb_nxt   = sub ? ~B : B;
                    carry_nxt = sub;
                    sub_nxt   = sub;
                    idx_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                sum_nxt[{idx, 3'b000} +: SLICE_W] = add_s;
                carry_nxt = add_co;
                idx_nxt   = idx + IDX_W'(1);
                if (idx == IDX_W'(3)) begin
                    cout_nxt  = add_co;
                    // Overflow uses the inverted B operand and the final sign bit.
                    ovf_nxt   = (opa[WORD_W-1] == opb[WORD_W-1]) &&
                                (add_s[SLICE_W-1] != opa[WORD_W-1]);
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
    end
endmodule

// File: tb/tb_add32_seq_ctrl.sv
// Directed and random checks of add32_seq_ctrl with a result scoreboard.

module tb_add32_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [31:0] A, B;
    logic [31:0] Sum;
    logic        Cout, Ovf, busy, done;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    add32_seq_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .Sum   (Sum),
        .Cout  (Cout),
        .Ovf   (Ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 33-bit arithmetic with an independent overflow rule.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t        e;
        logic [32:0] r;
        logic signed [33:0] sr;
        r  = s ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
        sr = s ? (34'(signed'(a)) - 34'(signed'(b))) : (34'(signed'(a)) + 34'(signed'(b)));
        e.sum  = r[31:0];
        e.cout = r[32];
        e.ovf  = (sr > 34'sd2147483647) || (sr < -34'sd2147483648);
        return e;
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input exp_t e, input bit poke, input string tag);
        exp_t got;
        int   cyc, bcnt, dcnt;
        @(negedge clk);
        A = a; B = b; sub = s; start = 1'b1;
        sbq.push_back(e);
        cyc = 0; bcnt = 0; dcnt = 0;
        while (dcnt == 0 && cyc < 12) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (poke && cyc == 2) begin
                start = 1'b1; A = '1; B = '1; sub = 1'b1;
            end
            if (busy) bcnt++;
            if (done) dcnt++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'd5);
        check({tag, " busy_cycles"}, 32'(bcnt), 32'd4);
        check({tag, " done_seen"}, 32'(dcnt), 32'd1);
        if (sbq.size() > 0) begin
            got = sbq.pop_front();
            check({tag, " sum"}, Sum, got.sum);
            check({tag, " cout"}, 32'(Cout), 32'(got.cout));
            check({tag, " ovf"}, 32'(Ovf), 32'(got.ovf));
        end else begin
            check({tag, " scoreboard_empty"}, 32'(sbq.size()), 32'd1);
        end
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] ra, rb, held;
        logic        rs;
        int          dcnt;

        rst = 1'b1; start = 1'b1; sub = 1'b0; A = 32'hDEADBEEF; B = 32'h1;
        repeat (2) @(negedge clk);
        check("reset sum", Sum, 32'h0);
        check("reset cout", 32'(Cout), 32'd0);
        check("reset ovf", 32'(Ovf), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("idle after reset busy", 32'(busy), 32'd0);

        do_op(32'h000000FF, 32'h00000001, 1'b0, '{32'h00000100, 1'b0, 1'b0}, 1'b0, "ff_plus_1");
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, '{32'h00000000, 1'b1, 1'b0}, 1'b0, "ripple_all");
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, '{32'h80000000, 1'b0, 1'b1}, 1'b0, "pos_ovf");
        do_op(32'h80000000, 32'h00000001, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1}, 1'b0, "neg_ovf_sub");
        do_op(32'h00000005, 32'h00000007, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0}, 1'b0, "sub_borrow");

        // Outputs hold while idle
        held = Sum;
        repeat (3) @(negedge clk);
        check("idle hold sum", Sum, held);

        do_op(32'h12345678, 32'h11111111, 1'b0, '{32'h23456789, 1'b0, 1'b0}, 1'b1, "start_ignored");
        repeat (3) @(negedge clk);
        check("no queued op busy", 32'(busy), 32'd0);
        check("no queued op sum", Sum, 32'h23456789);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            e = model(ra, rb, rs);
            do_op(ra, rb, rs, e, 1'b0, $sformatf("rand%0d", i));
        end

        // Abort in the second RUN cycle
        @(negedge clk);
        A = 32'h01010101; B = 32'h01010101; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort busy before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort sum", Sum, 32'h0);
        check("abort cout", 32'(Cout), 32'd0);
        check("abort ovf", 32'(Ovf), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("start under reset", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0;
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("aborted no done", 32'(dcnt), 32'd0);
        do_op(32'h00000001, 32'h00000002, 1'b0, '{32'h00000003, 1'b0, 1'b0}, 1'b0, "after_abort");
        check("scoreboard drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/add32_seq_ctrl.md
ADD32_SEQ_CTRL -- requirements
Module: add32_seq_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: start  input  1  request to begin an operation, sampled only in IDLE.
REQ-004 SHALL have ports: sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-005 SHALL have ports: A  input  32  operand A; sampled with start.
REQ-006 SHALL have ports: B  input  32  operand B; sampled with start.
REQ-007 SHALL have ports: Sum  output  32  result register.
REQ-008 SHALL have ports: Cout  output  1  carry out of bit 31 (for sub, 1 = no borrow).
REQ-009 SHALL have ports: Ovf  output  1  signed two's-complement overflow.
REQ-010 SHALL have ports: busy  output  1  high while an operation is in progress.
REQ-011 SHALL have ports: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have no parameters; widths fixed at 32-bit word, 8-bit slice.

Function
REQ-013 SHALL compute the 32-bit result with exactly one instance of the existing 8-bit ripple-carry adder, time-multiplexed over 4 byte slices, LSB first.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE, plus a 2-bit byte index idx.
REQ-015 IDLE, start=1 at an edge: latch A into opA, latch B into opB (B inverted when sub=1), set carry register to sub, latch sub, set idx=0, go to RUN.
REQ-016 IDLE, start=0: remain in IDLE; outputs hold.
REQ-017 RUN, each edge: adder inputs are opA[8*idx+7:8*idx], opB[8*idx+7:8*idx], carry.
REQ-018 RUN, each edge: Sum[8*idx+7:8*idx] <= adder sum; carry <= adder carry-out; idx <= idx+1.
REQ-019 RUN at idx=3: additionally load Cout <= adder carry-out, load Ovf, go to DONE.
REQ-020 Ovf SHALL equal (opA[31] == opB[31]) && (Sum[31] != opA[31]), using the already-inverted opB and the final Sum[31].
REQ-021 DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
REQ-022 busy SHALL be 1 in RUN, 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-023 Latency: start accepted at edge k -> done high in the cycle following edge k+4; next start accepted no earlier than edge k+6.
REQ-024 start in RUN or DONE SHALL be ignored; no queuing; operands of the active operation unaffected by input changes after edge k.
REQ-025 Sum SHALL be updated byte-wise during RUN; Sum, Cout, Ovf are valid from the DONE cycle and held until the first RUN edge of the next operation.
REQ-026 Arithmetic SHALL be modulo 2^32; no saturation.

Reset
REQ-027 rst=1 SHALL immediately (asynchronously) force: state IDLE, idx 0, carry 0, opA/opB 0, Sum 0x00000000, Cout 0, Ovf 0, busy 0, done 0.
REQ-028 rst asserted mid-operation SHALL abort it; no done pulse for the aborted operation.
REQ-029 start coincident with rst=1 SHALL be ignored; first acceptable start is at the first edge with rst=0.

Verification
REQ-030 A=0x000000FF, B=0x00000001, sub=0 -> Sum=0x00000100, Cout=0, Ovf=0, done one cycle wide, in the cycle after edge k+4.
REQ-031 A=0xFFFFFFFF, B=0x00000001, sub=0 -> Sum=0x00000000, Cout=1, Ovf=0 (carry rippled through all 4 slices).
REQ-032 A=0x7FFFFFFF, B=0x00000001, sub=0 -> Sum=0x80000000, Cout=0, Ovf=1; A=0x80000000, B=0x00000001, sub=1 -> Sum=0x7FFFFFFF, Cout=1, Ovf=1.
REQ-033 A=0x00000005, B=0x00000007, sub=1 -> Sum=0xFFFFFFFE, Cout=0, Ovf=0.
REQ-034 Start A=0x12345678, B=0x11111111; during RUN pulse start with A=B=0xFFFFFFFF -> result Sum=0x23456789, single done pulse, busy stays 1 for exactly 4 cycles.
REQ-035 Assert rst in the 2nd RUN cycle -> all outputs 0 immediately, no done; release, start A=1, B=2, sub=0 -> Sum=0x00000003.
